dac_xfer_buffer: RTL and testbench

- Parametrised single-clock transmit buffer between the DMA stream and the multi-lane JESD204 DAC transport.
- Successor to the fixed-width, bypass-only TX FIFO path.
- Generalised in channel count, sample width and depth.
- Adds three runtime modes: bypass, streaming FIFO and cyclic (DDS-style) replay, plus sticky underflow reporting.

---
 rtl/dac_xfer_pkg.sv | 21 ++
 rtl/dac_xfer_mem.sv | 26 ++
 rtl/dac_xfer_buffer.sv | 181 ++++++++++++++++++
 tb/tb_dac_xfer_buffer.sv | 227 ++++++++++++++++++++++
 4 files changed

// File: rtl/dac_xfer_pkg.sv
// Shared constants, state encodings and the mode decode for the DAC transmit buffer.
package dac_xfer_pkg;

  localparam int DEF_NUM_CHANNELS  = 4;
  localparam int DEF_CHANNEL_WIDTH = 16;
  localparam int DEF_DEPTH         = 1024;

  localparam logic [2:0] ST_IDLE    = 3'd0;
  localparam logic [2:0] ST_BYPASS  = 3'd1;
  localparam logic [2:0] ST_STREAM  = 3'd2;
  localparam logic [2:0] ST_CAPTURE = 3'd3;
  localparam logic [2:0] ST_PLAY    = 3'd4;

  // State entered from IDLE; bypass overrides cyclic.
  function automatic logic [2:0] mode_decode(input logic bypass, input logic cyclic);
    if (bypass)      return ST_BYPASS;
    else if (cyclic) return ST_CAPTURE;
    else             return ST_STREAM;
  endfunction

endpackage

// File: rtl/dac_xfer_mem.sv
// Simple dual-port sample RAM: one write port, one read port with a registered output.
module dac_xfer_mem
  import dac_xfer_pkg::*;
#(
  parameter int DEPTH      = DEF_DEPTH,
  parameter int WIDTH      = DEF_NUM_CHANNELS * DEF_CHANNEL_WIDTH,
  parameter int ADDR_WIDTH = $clog2(DEPTH)
) (
  input  logic                  clk,
  input  logic                  i_wr_en,
  input  logic [ADDR_WIDTH-1:0] i_wr_addr,
  input  logic [WIDTH-1:0]      i_wr_data,
  input  logic                  i_rd_en,
  input  logic [ADDR_WIDTH-1:0] i_rd_addr,
  output logic [WIDTH-1:0]      o_rd_data
);

  logic [WIDTH-1:0] r_mem [DEPTH];

  // Read data only changes on a read, so it doubles as the held output sample.
  always_ff @(posedge clk) begin
    if (i_wr_en) r_mem[i_wr_addr] <= i_wr_data;
    if (i_rd_en) o_rd_data <= r_mem[i_rd_addr];
  end

endmodule

// File: rtl/dac_xfer_buffer.sv
// DMA-to-DAC transmit buffer with bypass, streaming FIFO and cyclic replay modes.
// Build option: DAC_XFER_BUFFER_HOLD_LAST_EN makes idle/underflow output hold the last sample.
module dac_xfer_buffer
  import dac_xfer_pkg::*;
#(
  parameter int NUM_CHANNELS  = DEF_NUM_CHANNELS,
  parameter int CHANNEL_WIDTH = DEF_CHANNEL_WIDTH,
  parameter int DEPTH         = DEF_DEPTH,
  parameter int ADDR_WIDTH    = $clog2(DEPTH)
) (
  input  logic                                clk,
  input  logic                                resetn,
  input  logic                                bypass,
  input  logic                                cyclic,
  input  logic                                din_valid,
  output logic                                din_ready,
  input  logic [NUM_CHANNELS*CHANNEL_WIDTH-1:0] din_data,
  input  logic                                din_last,
  input  logic                                dac_valid,
  output logic [NUM_CHANNELS*CHANNEL_WIDTH-1:0] dac_data,
  output logic                                dac_underflow,
  input  logic                                underflow_clr,
  output logic [ADDR_WIDTH:0]                 fill_level,
  output logic [2:0]                          o_dbg_state
);

  localparam int DW = NUM_CHANNELS * CHANNEL_WIDTH;
  localparam logic [ADDR_WIDTH:0] FULL_CNT = DEPTH[ADDR_WIDTH:0];

  // Handshake: a DMA beat transfers on a cycle where din_valid and din_ready are both 1;
  // din_ready never depends on din_valid. dac_valid is a request strobe with no back-pressure.

  logic [2:0]            r_state;
  logic [1:0]            r_mode_q;
  logic [ADDR_WIDTH-1:0] r_wr_ptr;
  logic [ADDR_WIDTH-1:0] r_rd_ptr;
  logic [ADDR_WIDTH-1:0] r_last_addr;
  logic [ADDR_WIDTH:0]   r_count;
  logic                  r_src_mem;
  logic [DW-1:0]         r_out;
  logic                  r_underflow;

  logic          w_flush;
  logic          w_din_ready;
  logic          w_push;
  logic          w_pop;
  logic          w_dec;
  logic          w_uf_set;
  logic          w_idle_out;
  logic          w_byp_load;
  logic          w_capture_end;
  logic [DW-1:0] w_mem_rdata;

  assign w_flush = ({bypass, cyclic} != r_mode_q);

  always_comb begin
    w_din_ready = 1'b0;
    w_push      = 1'b0;
    w_pop       = 1'b0;
    w_uf_set    = 1'b0;
    w_idle_out  = 1'b0;
    w_byp_load  = 1'b0;
    if (w_flush) begin
      w_idle_out = dac_valid;
    end else begin
      case (r_state)
        ST_BYPASS: begin
          w_din_ready = dac_valid;
          w_byp_load  = dac_valid & din_valid;
          w_uf_set    = dac_valid & ~din_valid;
          w_idle_out  = dac_valid & ~din_valid;
        end
        ST_STREAM: begin
          // Empty is judged on the registered count, so a same-cycle write cannot be read.
          w_din_ready = (r_count != FULL_CNT);
          w_push      = din_valid & w_din_ready;
          w_pop       = dac_valid & (r_count != '0);
          w_uf_set    = dac_valid & (r_count == '0);
          w_idle_out  = dac_valid & (r_count == '0);
        end
        ST_CAPTURE: begin
          w_din_ready = 1'b1;
          w_push      = din_valid;
          w_idle_out  = dac_valid;
        end
        ST_PLAY: begin
          w_pop = dac_valid;
        end
        default: begin
          w_idle_out = dac_valid;
        end
      endcase
    end
  end

  assign w_dec         = w_pop & (r_state == ST_STREAM);
  assign w_capture_end = (r_state == ST_CAPTURE) & w_push &
                         (din_last | (r_count == FULL_CNT - 1'b1));

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state     <= ST_IDLE;
      r_mode_q    <= 2'b00;
      r_wr_ptr    <= '0;
      r_rd_ptr    <= '0;
      r_last_addr <= '0;
      r_count     <= '0;
    end else begin
      r_mode_q <= {bypass, cyclic};
      if (w_flush) begin
        r_state     <= ST_IDLE;
        r_wr_ptr    <= '0;
        r_rd_ptr    <= '0;
        r_last_addr <= '0;
        r_count     <= '0;
      end else begin
        if (r_state == ST_IDLE) r_state <= mode_decode(bypass, cyclic);
        if (w_capture_end) begin
          r_last_addr <= r_wr_ptr;
          r_state     <= ST_PLAY;
        end
        if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
        if (w_pop) begin
          if ((r_state == ST_PLAY) && (r_rd_ptr == r_last_addr)) r_rd_ptr <= '0;
          else                                                   r_rd_ptr <= r_rd_ptr + 1'b1;
        end
        case ({w_push, w_dec})
          2'b10:   r_count <= r_count + 1'b1;
          2'b01:   r_count <= r_count - 1'b1;
          default: r_count <= r_count;
        endcase
      end
    end
  end

  // Output source: r_out carries bypass/idle data, the RAM read register carries buffered samples.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_src_mem   <= 1'b0;
      r_out       <= '0;
      r_underflow <= 1'b0;
    end else begin
      if (w_byp_load) begin
        r_src_mem <= 1'b0;
        r_out     <= din_data;
      end else if (w_pop) begin
        r_src_mem <= 1'b1;
      end else if (w_idle_out) begin
`ifdef DAC_XFER_BUFFER_HOLD_LAST_EN
        r_src_mem <= r_src_mem;
`else
        r_src_mem <= 1'b0;
        r_out     <= '0;
`endif
      end
      if (w_uf_set)           r_underflow <= 1'b1;
      else if (underflow_clr) r_underflow <= 1'b0;
    end
  end

  dac_xfer_mem #(
    .DEPTH      (DEPTH),
    .WIDTH      (DW),
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_mem (
    .clk       (clk),
    .i_wr_en   (w_push),
    .i_wr_addr (r_wr_ptr),
    .i_wr_data (din_data),
    .i_rd_en   (w_pop),
    .i_rd_addr (r_rd_ptr),
    .o_rd_data (w_mem_rdata)
  );

  assign din_ready     = w_din_ready;
  assign dac_data      = r_src_mem ? w_mem_rdata : r_out;
  assign dac_underflow = r_underflow;
  assign fill_level    = r_count;
  assign o_dbg_state   = r_state;

endmodule

// File: tb/tb_dac_xfer_buffer.sv
// Directed bench for dac_xfer_buffer (4 channels x 16 bits, depth 16): vector table plus sequences.
module tb_dac_xfer_buffer;

  localparam int DW = 64;
  localparam logic [2:0] S_IDLE = 3'd0, S_BYPASS = 3'd1, S_STREAM = 3'd2, S_CAPTURE = 3'd3, S_PLAY = 3'd4;
`ifdef DAC_XFER_BUFFER_HOLD_LAST_EN
  localparam bit HOLD = 1'b1;
`else
  localparam bit HOLD = 1'b0;
`endif
  localparam logic [DW-1:0] B_VAL = 64'h1234_5678_9ABC_DEF0;
  localparam logic [DW-1:0] LAST_POP = 64'h000F_000F_000F_000F;
  localparam logic [DW-1:0] IDLE1 = HOLD ? LAST_POP : 64'h0;
  localparam logic [DW-1:0] IDLE2 = HOLD ? B_VAL : 64'h0;

  logic          clk = 1'b0;
  logic          resetn = 1'b0;
  logic          bypass = 1'b0;
  logic          cyclic = 1'b0;
  logic          din_valid = 1'b0;
  logic          din_ready;
  logic [DW-1:0] din_data = '0;
  logic          din_last = 1'b0;
  logic          dac_valid = 1'b0;
  logic [DW-1:0] dac_data;
  logic          dac_underflow;
  logic          underflow_clr = 1'b0;
  logic [4:0]    fill_level;
  logic [2:0]    dbg_state;

  int n_checks = 0;
  int n_pass   = 0;

  typedef struct {
    logic          bp, cy, dv;
    logic [DW-1:0] d;
    logic          av, clr;
    logic          exp_rdy;
    logic [DW-1:0] exp_data;
    logic          exp_uf;
    logic [4:0]    exp_fill;
  } vec_t;

  vec_t vt[12];

  dac_xfer_buffer #(
    .NUM_CHANNELS  (4),
    .CHANNEL_WIDTH (16),
    .DEPTH         (16)
  ) dut (
    .clk           (clk),
    .resetn        (resetn),
    .bypass        (bypass),
    .cyclic        (cyclic),
    .din_valid     (din_valid),
    .din_ready     (din_ready),
    .din_data      (din_data),
    .din_last      (din_last),
    .dac_valid     (dac_valid),
    .dac_data      (dac_data),
    .dac_underflow (dac_underflow),
    .underflow_clr (underflow_clr),
    .fill_level    (fill_level),
    .o_dbg_state   (dbg_state)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  // Drive one cycle of inputs, sample din_ready before the edge, return #1 after the edge.
  task automatic step(input logic bp, input logic cy, input logic dv, input logic [DW-1:0] d,
                      input logic lst, input logic av, input logic clr, output logic rdy);
    bypass = bp; cyclic = cy; din_valid = dv; din_data = d;
    din_last = lst; dac_valid = av; underflow_clr = clr;
    #1 rdy = din_ready;
    @(posedge clk);
    #1;
  endtask

  function automatic logic [DW-1:0] sval(input int i);
    logic [15:0] x;
    x = i[15:0];
    return {x, x, x, x};
  endfunction

  function automatic logic [DW-1:0] cval(input int i);
    logic [15:0] x;
    x = i[15:0];
    return {16'hC000 | x, 16'hA000 | x, 16'h5000 | x, x};
  endfunction

  initial begin
    logic rdy;
    logic [DW-1:0] x;

    vt[0]  = '{1'b0, 1'b0, 1'b0, 64'h0,  1'b1, 1'b0, 1'b1, IDLE1, 1'b1, 5'd0};
    vt[1]  = '{1'b0, 1'b0, 1'b0, 64'h0,  1'b0, 1'b0, 1'b1, IDLE1, 1'b1, 5'd0};
    vt[2]  = '{1'b0, 1'b0, 1'b0, 64'h0,  1'b0, 1'b1, 1'b1, IDLE1, 1'b0, 5'd0};
    vt[3]  = '{1'b0, 1'b0, 1'b0, 64'h0,  1'b1, 1'b0, 1'b1, IDLE1, 1'b1, 5'd0};
    vt[4]  = '{1'b0, 1'b0, 1'b0, 64'h0,  1'b1, 1'b1, 1'b1, IDLE1, 1'b1, 5'd0};
    vt[5]  = '{1'b0, 1'b0, 1'b0, 64'h0,  1'b0, 1'b1, 1'b1, IDLE1, 1'b0, 5'd0};
    vt[6]  = '{1'b1, 1'b0, 1'b0, 64'h0,  1'b0, 1'b0, 1'b0, IDLE1, 1'b0, 5'd0};
    vt[7]  = '{1'b1, 1'b0, 1'b0, 64'h0,  1'b0, 1'b0, 1'b0, IDLE1, 1'b0, 5'd0};
    vt[8]  = '{1'b1, 1'b0, 1'b1, B_VAL,  1'b1, 1'b0, 1'b1, B_VAL, 1'b0, 5'd0};
    vt[9]  = '{1'b1, 1'b0, 1'b1, '1,     1'b0, 1'b0, 1'b0, B_VAL, 1'b0, 5'd0};
    vt[10] = '{1'b1, 1'b0, 1'b0, 64'h0,  1'b1, 1'b0, 1'b1, IDLE2, 1'b1, 5'd0};
    vt[11] = '{1'b1, 1'b0, 1'b0, 64'h0,  1'b0, 1'b1, 1'b0, IDLE2, 1'b0, 5'd0};

    // Reset values
    #1;
    check("rst_data", dac_data, 64'h0);
    check("rst_rdy", din_ready, 1'b0);
    check("rst_uf", dac_underflow, 1'b0);
    check("rst_fill", fill_level, 5'd0);
    check("rst_state", dbg_state, S_IDLE);
    @(posedge clk);
    #1 resetn = 1'b1;
    step(0, 0, 0, '0, 0, 0, 0, rdy);
    check("stream_state", dbg_state, S_STREAM);

    // STREAM: fill to full, then drain in order
    for (int i = 0; i < 16; i++) begin
      step(0, 0, 1, sval(i), 0, 0, 0, rdy);
      check($sformatf("fill_rdy%0d", i), rdy, 1'b1);
      check($sformatf("fill_lvl%0d", i), fill_level, 64'(i + 1));
    end
    step(0, 0, 1, '1, 0, 0, 0, rdy);
    check("full_rdy", rdy, 1'b0);
    check("full_lvl", fill_level, 5'd16);
    for (int i = 0; i < 16; i++) begin
      step(0, 0, 0, '0, 0, 1, 0, rdy);
      check($sformatf("pop_data%0d", i), dac_data, sval(i));
      check($sformatf("pop_lvl%0d", i), fill_level, 64'(15 - i));
    end
    check("drain_uf", dac_underflow, 1'b0);

    // Underflow and bypass vectors
    for (int k = 0; k < 12; k++) begin
      step(vt[k].bp, vt[k].cy, vt[k].dv, vt[k].d, 0, vt[k].av, vt[k].clr, rdy);
      check($sformatf("vec%0d_rdy", k), rdy, vt[k].exp_rdy);
      check($sformatf("vec%0d_data", k), dac_data, vt[k].exp_data);
      check($sformatf("vec%0d_uf", k), dac_underflow, vt[k].exp_uf);
      check($sformatf("vec%0d_fill", k), fill_level, vt[k].exp_fill);
    end

    // CYCLIC: capture A..E, then replay
    step(0, 1, 0, '0, 0, 0, 0, rdy);
    check("cyc_flush_state", dbg_state, S_IDLE);
    step(0, 1, 0, '0, 0, 0, 0, rdy);
    check("cyc_capture_state", dbg_state, S_CAPTURE);
    step(0, 1, 0, '0, 0, 1, 0, rdy);
    check("capture_idle_data", dac_data, IDLE2);
    check("capture_idle_uf", dac_underflow, 1'b0);
    for (int i = 0; i < 5; i++) begin
      step(0, 1, 1, cval(i), (i == 4), 0, 0, rdy);
      check($sformatf("cap_rdy%0d", i), rdy, 1'b1);
      check($sformatf("cap_lvl%0d", i), fill_level, 64'(i + 1));
    end
    check("play_state", dbg_state, S_PLAY);
    step(0, 1, 1, '1, 0, 0, 0, rdy);
    check("play_rdy", rdy, 1'b0);
    for (int k = 0; k < 12; k++) begin
      step(0, 1, 0, '0, 0, 1, 0, rdy);
      check($sformatf("replay5_%0d", k), dac_data, cval(k % 5));
      check($sformatf("replay5_lvl%0d", k), fill_level, 5'd5);
    end
    check("replay_uf", dac_underflow, 1'b0);

    // Flush mid-PLAY back to STREAM; first write must land at address 0
    step(0, 0, 1, '1, 0, 0, 0, rdy);
    check("flush_rdy", rdy, 1'b0);
    check("flush_lvl", fill_level, 5'd0);
    check("flush_state", dbg_state, S_IDLE);
    step(0, 0, 0, '0, 0, 0, 0, rdy);
    check("flush_stream_state", dbg_state, S_STREAM);
    x = 64'hFACE_0000_BEEF_0001;
    step(0, 0, 1, x, 0, 0, 0, rdy);
    check("post_flush_lvl", fill_level, 5'd1);
    step(0, 0, 0, '0, 0, 1, 0, rdy);
    check("post_flush_data", dac_data, x);
    check("post_flush_lvl0", fill_level, 5'd0);

    // CYCLIC with no din_last: capture stops at DEPTH beats
    step(0, 1, 0, '0, 0, 0, 0, rdy);
    step(0, 1, 0, '0, 0, 0, 0, rdy);
    for (int i = 0; i < 20; i++) begin
      step(0, 1, 1, cval(i), 0, 0, 0, rdy);
      check($sformatf("cap16_rdy%0d", i), rdy, (i < 16));
      check($sformatf("cap16_lvl%0d", i), fill_level, (i < 16) ? 64'(i + 1) : 64'd16);
    end
    check("cap16_state", dbg_state, S_PLAY);
    for (int k = 0; k < 20; k++) begin
      step(0, 1, 0, '0, 0, 1, 0, rdy);
      check($sformatf("replay16_%0d", k), dac_data, cval(k % 16));
    end

    // Asynchronous reset mid-STREAM
    step(0, 0, 0, '0, 0, 0, 0, rdy);
    step(0, 0, 0, '0, 0, 0, 0, rdy);
    step(0, 0, 0, '0, 0, 1, 0, rdy);
    check("pre_rst_uf", dac_underflow, 1'b1);
    for (int i = 0; i < 3; i++) step(0, 0, 1, cval(i + 40), 0, 0, 0, rdy);
    step(0, 0, 0, '0, 0, 1, 0, rdy);
    check("pre_rst_data", dac_data, cval(40));
    check("pre_rst_lvl", fill_level, 5'd2);
    din_valid = 1'b1;
    resetn = 1'b0;
    #1;
    check("arst_data", dac_data, 64'h0);
    check("arst_rdy", din_ready, 1'b0);
    check("arst_uf", dac_underflow, 1'b0);
    check("arst_lvl", fill_level, 5'd0);
    check("arst_state", dbg_state, S_IDLE);
    @(posedge clk);
    #1 resetn = 1'b1;
    din_valid = 1'b0;

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
